// File: rtl/wavelet_sample_tx.sv
// Wavelet sample transmitter: buffers samples from a valid/ready source and
// replays each one on the o_value / o_data_clk pin pair with programmable
// setup, high and hold dwell times.
module wavelet_sample_tx #(
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int SETUP_CYCLES = 2,
    parameter int HIGH_CYCLES  = 2,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_enable,
    input  logic [WIDTH-1:0]              i_sample,
    input  logic                          i_sample_valid,
    output logic                          o_sample_ready,
    output logic [WIDTH-1:0]              o_value,
    output logic                          o_data_clk,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [15:0]                   o_sent_count
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int MAXC = (SETUP_CYCLES > HIGH_CYCLES)
                          ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                          : ((HIGH_CYCLES > HOLD_CYCLES) ? HIGH_CYCLES : HOLD_CYCLES);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    // Dwell counters count down to zero, so each load is (cycles - 1).
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] HIGH_LOAD  = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   dwell, dwell_next;
    logic            pop, sent_inc, push;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             fifo_nonempty;

    assign o_sample_ready = (count != FULL_CNT);
    assign fifo_nonempty  = (count != '0);
    assign push           = i_sample_valid && o_sample_ready;
    assign o_busy         = (state != IDLE);
    assign o_fifo_count   = count;

    // Sample storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_sample;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, dwell counter and pop/count strobes.
    always_comb begin
        state_next = state;
        dwell_next = dwell;
        pop        = 1'b0;
        sent_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (i_enable && fifo_nonempty) begin
                    pop        = 1'b1;
                    state_next = SETUP;
                    dwell_next = SETUP_LOAD;
                end
            end
            SETUP: begin
                if (dwell == '0) begin
                    state_next = HIGH;
                    dwell_next = HIGH_LOAD;
                end else begin
                    dwell_next = dwell - CW'(1);
                end
            end
            HIGH: begin
                if (dwell == '0) begin
                    state_next = HOLD;
                    dwell_next = HOLD_LOAD;
                    sent_inc   = 1'b1;
                end else begin
                    dwell_next = dwell - CW'(1);
                end
            end
            HOLD: begin
                if (dwell == '0) begin
                    // Chain straight into the next frame when possible, no IDLE gap.
                    if (i_enable && fifo_nonempty) begin
                        pop        = 1'b1;
                        state_next = SETUP;
                        dwell_next = SETUP_LOAD;
                    end else begin
                        state_next = IDLE;
                        dwell_next = '0;
                    end
                end else begin
                    dwell_next = dwell - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                dwell_next = '0;
            end
        endcase
    end

    // Dwell counter, registered pin outputs and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell        <= '0;
            o_data_clk   <= 1'b0;
            o_value      <= '0;
            o_sent_count <= '0;
        end else begin
            dwell      <= dwell_next;
            o_data_clk <= (state_next == HIGH);
            if (pop) begin
                o_value <= mem[rd_ptr];
            end
            if (sent_inc) begin
                o_sent_count <= o_sent_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_wavelet_sample_tx.sv
// Self-checking bench for wavelet_sample_tx: directed scenarios plus random
// traffic, compared every cycle against a frame-timeline reference model.
module tb_wavelet_sample_tx;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int H     = 2;
    localparam int D     = 2;
    localparam int P     = S + H + D;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_enable;
    logic [WIDTH-1:0] i_sample;
    logic             i_sample_valid;
    logic             o_sample_ready;
    logic [WIDTH-1:0] o_value;
    logic             o_data_clk;
    logic             o_busy;
    logic [2:0]       o_fifo_count;
    logic [15:0]      o_sent_count;

    wavelet_sample_tx #(
        .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH),
        .SETUP_CYCLES(S), .HIGH_CYCLES(H), .HOLD_CYCLES(D)
    ) dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_sample(i_sample), .i_sample_valid(i_sample_valid),
        .o_sample_ready(o_sample_ready), .o_value(o_value),
        .o_data_clk(o_data_clk), .o_busy(o_busy),
        .o_fifo_count(o_fifo_count), .o_sent_count(o_sent_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a buffer queue plus the elapsed cycle count of the current frame.
    logic [WIDTH-1:0] mq[$];
    logic [WIDTH-1:0] sb[$];
    bit               m_busy = 0;
    int               m_t = 0;
    logic [15:0]      m_sent = 0;
    logic [WIDTH-1:0] m_value = 0;
    bit               m_acc = 0;
    bit               prev_clk = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        int  old_size;
        bit  do_pop;
        if (rst) begin
            mq.delete();
            sb.delete();
            m_busy  = 0;
            m_t     = 0;
            m_sent  = 0;
            m_value = 0;
            m_acc   = 0;
            return;
        end
        old_size = mq.size();
        m_acc    = i_sample_valid && (old_size != DEPTH);
        do_pop   = 0;
        if (m_busy) begin
            m_t++;
            if (m_t == S + H) m_sent++;
            if (m_t == P) begin
                m_t = 0;
                if (i_enable && old_size > 0) do_pop = 1;
                else m_busy = 0;
            end
        end else if (i_enable && old_size > 0) begin
            do_pop = 1;
            m_busy = 1;
            m_t    = 0;
        end
        if (do_pop) m_value = mq.pop_front();
        if (m_acc) begin
            mq.push_back(i_sample);
            sb.push_back(i_sample);
        end
    endtask

    task automatic compare_all();
        logic exp_clk;
        exp_clk = m_busy && (m_t >= S) && (m_t < S + H);
        chk("value", 32'(o_value), 32'(m_value));
        chk("data_clk", 32'(o_data_clk), 32'(exp_clk));
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("fifo_count", 32'(o_fifo_count), 32'(mq.size()));
        chk("ready", 32'(o_sample_ready), 32'(mq.size() != DEPTH));
        chk("sent", 32'(o_sent_count), 32'(m_sent));
        // Each strobe rising edge must carry the next pushed sample.
        if (o_data_clk === 1'b1 && !prev_clk) begin
            if (sb.size() == 0) chk("sb_extra_pulse", 32'd1, 32'd0);
            else chk("sb_order", 32'(o_value), 32'(sb.pop_front()));
        end
        prev_clk = (o_data_clk === 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push_one(input logic [WIDTH-1:0] v);
        bit done;
        done = 0;
        i_sample       = v;
        i_sample_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            tick();
            done = m_acc;
        end
        i_sample_valid = 1'b0;
        if (!done) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_strobe_high();
        for (int k = 0; k < 50 && o_data_clk !== 1'b1; k++) tick();
        chk("wait_strobe", 32'(o_data_clk), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        i_enable       = 1'b0;
        i_sample       = '0;
        i_sample_valid = 1'b0;
        ticks(2);
        chk("reset_ready", 32'(o_sample_ready), 32'd1);
        chk("reset_value", 32'(o_value), 32'd0);
        rst = 1'b0;

        // Single sample.
        i_enable = 1'b1;
        push_one(8'hA5);
        tick();
        chk("t1_value", 32'(o_value), 32'hA5);
        ticks(2);
        chk("t1_strobe_rise", 32'(o_data_clk), 32'd1);
        tick();
        chk("t1_strobe_high2", 32'(o_data_clk), 32'd1);
        tick();
        chk("t1_strobe_fall", 32'(o_data_clk), 32'd0);
        ticks(6);
        chk("t1_sent", 32'(o_sent_count), 32'd1);
        chk("t1_idle", 32'(o_busy), 32'd0);

        // Burst of six pushed as fast as ready allows.
        for (int i = 1; i <= 6; i++) push_one(8'(i));
        ticks(40);
        chk("t2_sent", 32'(o_sent_count), 32'd7);

        // Disabled buffering, then release.
        i_enable = 1'b0;
        push_one(8'h31);
        push_one(8'h32);
        push_one(8'h33);
        tick();
        chk("t3_count", 32'(o_fifo_count), 32'd3);
        chk("t3_ready", 32'(o_sample_ready), 32'd1);
        chk("t3_strobe", 32'(o_data_clk), 32'd0);
        i_enable = 1'b1;
        ticks(25);
        chk("t3_sent", 32'(o_sent_count), 32'd10);

        // Enable dropped during HIGH of the first of three frames.
        push_one(8'h41);
        push_one(8'h42);
        push_one(8'h43);
        wait_strobe_high();
        i_enable = 1'b0;
        ticks(20);
        chk("t4_idle", 32'(o_busy), 32'd0);
        chk("t4_count", 32'(o_fifo_count), 32'd2);
        chk("t4_sent", 32'(o_sent_count), 32'd11);
        i_enable = 1'b1;
        ticks(20);
        chk("t4_resume_sent", 32'(o_sent_count), 32'd13);

        // Reset mid-HIGH.
        push_one(8'h5A);
        wait_strobe_high();
        rst = 1'b1;
        tick();
        chk("t5_strobe", 32'(o_data_clk), 32'd0);
        chk("t5_count", 32'(o_fifo_count), 32'd0);
        chk("t5_sent", 32'(o_sent_count), 32'd0);
        chk("t5_ready", 32'(o_sample_ready), 32'd1);
        chk("t5_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            i_enable       = ($urandom_range(0, 9) != 0);
            i_sample_valid = $urandom_range(0, 1) == 1;
            i_sample       = 8'($urandom);
            rst            = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst            = 1'b0;
        i_sample_valid = 1'b0;
        i_enable       = 1'b1;
        ticks(60);
        chk("drain_count", 32'(o_fifo_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
